// File: rtl/strip_pkg.sv
// strip_pkg: shared state type and cycle/address helpers for the LED strip drivers
package strip_pkg;

   typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_SEND, S_LATCH} state_t;

   function automatic int cyc_ns(input int freq_hz, input int ns);
      return (freq_hz / 1000000) * ns / 1000;
   endfunction

   function automatic int cyc_us(input int freq_hz, input int us);
      return (freq_hz / 1000000) * us;
   endfunction

   function automatic int byte_addr(input int ch, input int b, input int max_leds, input int bpl);
      return ch * max_leds * bpl + b;
   endfunction

endpackage

// File: rtl/strip_bit_encoder.sv
// strip_bit_encoder: one channel's byte shift register and single-wire pulse shaper
module strip_bit_encoder #(
   parameter int CW  = 5,
   parameter int T0H = 1,
   parameter int T1H = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          active,
   input  logic          load,
   input  logic          shift,
   input  logic [CW-1:0] phase,
   input  logic [7:0]    din,
   output logic          q
);

   logic [7:0] sr;
   logic       bit_v;

   // On the load cycle the register is not written yet, so take the MSB straight from din
   assign bit_v = load ? din[7] : sr[7];

   // Byte being sent: loaded at the byte boundary, shifted at the end of every bit
   always_ff @(posedge clk or negedge rst)
      if (!rst) sr <= '0;
      else if (load) sr <= din;
      else if (shift) sr <= {sr[6:0], 1'b0};

   // Output is high while the shared phase is inside this bit's high window
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= 1'b0;
      else q <= active && (phase < (bit_v ? CW'(T1H) : CW'(T0H)));

endmodule

// File: rtl/multi_strip_driver.sv
// multi_strip_driver: drives NUM_CHANNELS single-wire LED strips in lockstep from one byte-wide frame memory
module multi_strip_driver
   import strip_pkg::*;
#(
   parameter int INPUT_CLOCK_FREQ = 50000000,
   parameter int NUM_CHANNELS     = 4,
   parameter int MAX_LEDS         = 300,
   parameter int BYTES_PER_LED    = 3,
   parameter int ADDR_WIDTH       = 13,
   parameter int T0H_NS           = 400,
   parameter int T1H_NS           = 800,
   parameter int BIT_NS           = 1250,
   parameter int LATCH_US         = 50
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            auto_repeat,
   input  logic [$clog2(MAX_LEDS+1)-1:0]   led_count,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   input  logic [7:0]                      mem_data,
   output logic [NUM_CHANNELS-1:0]         strip_out,
   output logic                            busy,
   output logic                            frame_done
);

   localparam int CYC_T0H   = cyc_ns(INPUT_CLOCK_FREQ, T0H_NS);
   localparam int CYC_T1H   = cyc_ns(INPUT_CLOCK_FREQ, T1H_NS);
   localparam int CYC_BIT   = cyc_ns(INPUT_CLOCK_FREQ, BIT_NS);
   localparam int CYC_LATCH = cyc_us(INPUT_CLOCK_FREQ, LATCH_US);
   localparam int LCW       = $clog2(MAX_LEDS + 1);
   localparam int BW        = $clog2(MAX_LEDS * BYTES_PER_LED + 1);
   localparam int CNT_MAX   = CYC_LATCH > CYC_BIT ? CYC_LATCH : CYC_BIT;
   localparam int CW        = $clog2(CNT_MAX + 1);
   localparam int CHW       = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;

   if (!(CYC_T0H >= 1 && CYC_T1H > CYC_T0H && CYC_BIT > CYC_T1H && NUM_CHANNELS + 1 <= 8 * CYC_BIT)) begin : g_bad_params
      $error("multi_strip_driver: bit timing does not fit the clock frequency or channel count");
   end

   state_t          state, next_state;
   logic [LCW-1:0]  lc_clamp;
   logic [BW-1:0]   nb_in, nbytes, bc, fbyte;
   logic [CW-1:0]   cnt;
   logic [2:0]      bi;
   logic            fon, cap_v, ph_end, load, done, sample, last_ch;
   logic [CHW-1:0]  fch, cap_ch;
   logic [7:0]      pre   [NUM_CHANNELS];
   logic [7:0]      pre_d [NUM_CHANNELS];

   assign lc_clamp   = (led_count > LCW'(MAX_LEDS)) ? LCW'(MAX_LEDS) : led_count;
   assign nb_in      = BW'(lc_clamp) * BW'(BYTES_PER_LED);
   assign ph_end     = state == S_SEND && cnt == CW'(CYC_BIT - 1);
   assign load       = state == S_SEND && cnt == '0 && bi == 3'd7;
   assign done       = state == S_LATCH && cnt == CW'(CYC_LATCH - 1);
   assign sample     = (state == S_IDLE && start) || (done && auto_repeat);
   assign last_ch    = fch == CHW'(NUM_CHANNELS - 1);
   assign busy       = state != S_IDLE;
   assign frame_done = done;
   assign mem_addr   = ADDR_WIDTH'(byte_addr(int'(fch), int'(fbyte), MAX_LEDS, BYTES_PER_LED));

   // State register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= next_state;

   // Next-state logic; a zero-length frame goes straight to the latch gap
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:     if (start) next_state = nb_in == '0 ? S_LATCH : S_PREFETCH;
         S_PREFETCH: if (last_ch) next_state = S_SEND;
         S_SEND:     if (ph_end && bi == 3'd0 && bc == nbytes - BW'(1)) next_state = S_LATCH;
         S_LATCH:    if (done) next_state = !auto_repeat ? S_IDLE : (nb_in == '0 ? S_LATCH : S_PREFETCH);
         default:    next_state = S_IDLE;
      endcase
   end

   // Shared counter (bit phase in SEND, latch time in LATCH), bit index and byte index
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt <= '0;
         bi  <= 3'd7;
         bc  <= '0;
      end else begin
         cnt <= ((state == S_SEND && !ph_end) || (state == S_LATCH && !done)) ? cnt + CW'(1) : '0;
         bi  <= state != S_SEND ? 3'd7 : (ph_end ? bi - 3'd1 : bi);
         bc  <= state != S_SEND ? '0 : ((ph_end && bi == 3'd0) ? bc + BW'(1) : bc);
      end

   // Frame length in bytes, captured on every (re)start
   always_ff @(posedge clk or negedge rst)
      if (!rst) nbytes <= '0;
      else if (sample) nbytes <= nb_in;

   // Fetch sequencer: one read per channel for byte 0 at frame start, then the next byte at each byte boundary
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fon    <= 1'b0;
         fch    <= '0;
         fbyte  <= '0;
         cap_v  <= 1'b0;
         cap_ch <= '0;
      end else begin
         cap_v  <= fon;
         cap_ch <= fch;
         if (sample && nb_in != '0) begin
            fon   <= 1'b1;
            fch   <= '0;
            fbyte <= '0;
         end else if (load && bc + BW'(1) < nbytes) begin
            fon   <= 1'b1;
            fch   <= '0;
            fbyte <= bc + BW'(1);
         end else if (fon) begin
            fon <= !last_ch;
            fch <= last_ch ? '0 : fch + CHW'(1);
         end
      end

   // Capture returning read data into the addressed channel's prefetch register
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < NUM_CHANNELS; i++) pre[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) if (cap_v && cap_ch == CHW'(i)) pre[i] <= mem_data;
      end

   // Bypass so the last channel's first byte can be loaded in the cycle it arrives
   always_comb
      for (int i = 0; i < NUM_CHANNELS; i++) pre_d[i] = (cap_v && cap_ch == CHW'(i)) ? mem_data : pre[i];

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      strip_bit_encoder #(.CW(CW), .T0H(CYC_T0H), .T1H(CYC_T1H)) u_enc (
         .clk    (clk),
         .rst    (rst),
         .active (state == S_SEND),
         .load   (load),
         .shift  (ph_end),
         .phase  (cnt),
         .din    (pre_d[g]),
         .q      (strip_out[g])
      );
   end

endmodule

// File: doc/multi_strip_driver.md
# multi_strip_driver

Parametrised successor to the single-channel `strip_driver`. Drives NUM_CHANNELS WS2812-class single-wire LED strips in lockstep from one shared byte-wide frame memory, with 24- or 32-bit pixels. Frame length is set at run time, and the block supports one-shot or auto-repeat refresh. It sits between the frame buffer RAM and the strip output pins.

## Interface
- INPUT_CLOCK_FREQ, 50000000: `clk` frequency in Hz.
- NUM_CHANNELS, 4: number of strips, ≥1.
- MAX_LEDS, 300: LEDs per channel, upper bound.
- BYTES_PER_LED, 3: 3 for RGB or 4 for RGBW.
- ADDR_WIDTH, 13: width of `mem_addr`.
- T0H_NS, 400 / T1H_NS, 800 / BIT_NS, 1250: high time for a 0 bit, high time for a 1 bit, bit period.
- LATCH_US, 50: low time after each frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a frame.
- auto_repeat  in  1  level; when 1, the next frame starts automatically after latch.
- led_count  in  clog2(MAX_LEDS+1)  LEDs per channel, sampled on start; values above MAX_LEDS are clamped to MAX_LEDS.
- mem_addr  out  ADDR_WIDTH  byte address into the frame memory.
- mem_data  in  8  read data, valid exactly 1 cycle after `mem_addr`.
- strip_out  out  NUM_CHANNELS  serial outputs.
- busy  out  1  high from start acceptance through end of latch.
- frame_done  out  1  one-cycle pulse when latch completes.

## Operation
Cycle constants are computed from `INPUT_CLOCK_FREQ`:
- CYC_x = (INPUT_CLOCK_FREQ/1000000)*x_NS/1000.
- CYC_LATCH = (INPUT_CLOCK_FREQ/1000000)*LATCH_US.

Elaboration-time requirements: CYC_T0H ≥ 1, CYC_T1H > CYC_T0H, CYC_BIT > CYC_T1H, NUM_CHANNELS+1 ≤ 8*CYC_BIT.

Memory layout: channel c, byte b is at address c*MAX_LEDS*BYTES_PER_LED + b. Bytes go out in memory order, MSB first.

State machine:
- **IDLE**: outputs low, `busy` = 0. On `start`, latch `led_count` (clamped). Go to LATCH if the clamped count is 0, otherwise go to PREFETCH.
- **PREFETCH**: issue NUM_CHANNELS reads for byte 0, one per cycle, channel 0 first. Capture each read into the per-channel prefetch register. Then go to SEND.
- **SEND**: at each byte boundary, copy prefetch registers into shift registers, then immediately issue reads for the next byte index. Each bit period:
  - `strip_out[c]` is high for CYC_T1H cycles if its shift MSB is 1, otherwise CYC_T0H cycles.
  - It is then low for the rest of CYC_BIT.
  - After bit 0 of byte led_count*BYTES_PER_LED−1, go to LATCH.
- **LATCH**: all outputs low for CYC_LATCH cycles. Pulse `frame_done`. Then go to PREFETCH, with `led_count` resampled, if `auto_repeat`=1; otherwise go to IDLE.

Rules:
- `start` while busy is ignored.
- Clearing `auto_repeat` mid-frame takes effect at the end of the current latch.
- All channels share one bit/byte counter, so their bit edges are cycle-aligned.

## Timing
- Reset values: `strip_out`=0, `mem_addr`=0, `busy`=0, `frame_done`=0, state=IDLE. Async assertion forces all outputs low at once, including mid-bit.
- `busy` rises the cycle after `start`.
- First rising edge of `strip_out` occurs NUM_CHANNELS+2 cycles after `start`.
- Bit periods are exactly CYC_BIT with no gaps between bits, bytes or LEDs.
- `frame_done` is asserted on the last LATCH cycle. `busy` falls on the next cycle unless auto-repeat applies.
- Frame length: NUM_CHANNELS+1 + 8*BYTES_PER_LED*led_count*CYC_BIT + CYC_LATCH cycles.

## Structure
- A shared package `strip_pkg` holds:
  - the state enum;
  - the cycle-constant functions;
  - the address-computation function.
- One natural sub-module, `strip_bit_encoder`:
  - per channel: shift register, load, bit-phase compare, output flop;
  - instantiated NUM_CHANNELS times;
  - driven by the shared phase counter.
- The top level holds the FSM, counters, fetch sequencer and prefetch registers.

## Test plan
Bench configuration: INPUT_CLOCK_FREQ=16000000, NUM_CHANNELS=2, MAX_LEDS=5, BYTES_PER_LED=3. This gives CYC_T0H=6, CYC_T1H=12, CYC_BIT=20 and CYC_LATCH=800.

- Constant data: `mem_data`=8'h13, led_count=5, one start → each channel's high times are 6,6,6,12,6,6,12,12 per byte, repeated 15 times; both channels are identical and cycle-aligned; then 800 low cycles and `frame_done`.
- Addressing: memory returns the low byte of the address → channel 1's first byte is 8'd15 and its last byte is 8'd29.
- led_count=0 → no high pulses on either channel; `frame_done` pulses 801 cycles after start.
- auto_repeat=1 and led_count=1 → back-to-back frames, each 24 bits followed by 800 low cycles; clearing auto_repeat ends after the current frame.
- Reset asserted mid-bit during SEND → `strip_out`=0 in the same cycle; after release, state is IDLE and a new start produces a correct full frame.
- `start` pulsed during SEND, and led_count=7 → the start is ignored; 5 LEDs are sent due to clamping.
